// File: rtl/branch_predictor_if.sv
// Bundle of the fetch-side lookup channel, the execute-side training channel and the
// statistics outputs of the bimodal/gshare branch predictor.
//   master : fetch/execute/perf side (drives requests and updates, observes results)
//   slave  : the predictor itself
// Signals
//   pred_valid/pred_pc                 lookup request from fetch
//   pred_resp_valid/pred_taken/pred_hist  lookup result, one cycle later
//   upd_valid/upd_pc/upd_hist/upd_taken/upd_pred  resolved branch from execute
//   mispredict                          one-cycle pulse after a mispredicted update
//   stats_clr/br_count/mispred_count    saturating performance counters
interface branch_predictor_if #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CNT_W      = 32
);
  logic                  pred_valid;
  logic [31:0]           pred_pc;
  logic                  pred_resp_valid;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_hist;

  logic                  upd_valid;
  logic [31:0]           upd_pc;
  logic [INDEX_BITS-1:0] upd_hist;
  logic                  upd_taken;
  logic                  upd_pred;
  logic                  mispredict;

  logic                  stats_clr;
  logic [CNT_W-1:0]      br_count;
  logic [CNT_W-1:0]      mispred_count;

  modport master (
    output pred_valid, pred_pc,
    input  pred_resp_valid, pred_taken, pred_hist,
    output upd_valid, upd_pc, upd_hist, upd_taken, upd_pred,
    input  mispredict,
    output stats_clr,
    input  br_count, mispred_count
  );

  modport slave (
    input  pred_valid, pred_pc,
    output pred_resp_valid, pred_taken, pred_hist,
    input  upd_valid, upd_pc, upd_hist, upd_taken, upd_pred,
    output mispredict,
    input  stats_clr,
    output br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Branch direction predictor built from a table of 2-bit saturating counters.
// Fetch looks up a PC and gets a registered taken/not-taken guess one cycle later;
// execute feeds back resolved outcomes which train the indexed counter. Mispredicts
// are flagged with a one-cycle pulse and counted in saturating statistics counters.
//
// Optional feature: define BP_GSHARE_EN to keep a global history register and index
// the table with base(pc) XOR history (gshare). Without it the table is indexed by
// pc[INDEX_BITS+1:2] only and pred_hist is tied to 0.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : branch_predictor_if.slave (lookup, update and statistics signals)
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam logic [1:0]  CntWeakNt = 2'b01;

  typedef logic [INDEX_BITS-1:0] idx_t;

  // ---------------------------------------------------------------------------
  // Index generation
  // ---------------------------------------------------------------------------
  idx_t pred_base;
  idx_t upd_base;
  idx_t pred_idx;
  idx_t upd_idx;
  idx_t hist_cur;

  assign pred_base = bus.pred_pc[INDEX_BITS+1:2];
  assign upd_base  = bus.upd_pc[INDEX_BITS+1:2];

`ifdef BP_GSHARE_EN
  idx_t ghr_q;
  idx_t ghr_d;

  // History shifts in every resolved outcome; a lookup in the same cycle sees ghr_q,
  // i.e. the pre-shift value.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.upd_valid) begin
      ghr_d = {ghr_q[INDEX_BITS-2:0], bus.upd_taken};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign hist_cur = ghr_q;
  assign pred_idx = pred_base ^ ghr_q;
  // Update uses the history captured at prediction time, not the current one.
  assign upd_idx  = upd_base ^ bus.upd_hist;
`else
  logic unused_upd_hist;

  assign hist_cur        = '0;
  assign pred_idx        = pred_base;
  assign upd_idx         = upd_base;
  assign unused_upd_hist = ^bus.upd_hist;
`endif

  // PC bits outside the index field never influence the prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0],
                            bus.upd_pc[31:INDEX_BITS+2], bus.upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Counter table
  // ---------------------------------------------------------------------------
  logic [1:0] table_q [Entries];
  logic [1:0] upd_cnt;
  logic [1:0] upd_cnt_d;

  assign upd_cnt = table_q[upd_idx];

  always_comb begin
    upd_cnt_d = upd_cnt;
    if (bus.upd_taken) begin
      if (upd_cnt != 2'b11) begin
        upd_cnt_d = upd_cnt + 2'd1;
      end
    end else begin
      if (upd_cnt != 2'b00) begin
        upd_cnt_d = upd_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        table_q[i] <= CntWeakNt;
      end
    end else if (bus.upd_valid) begin
      table_q[upd_idx] <= upd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup response (registered). Reading table_q here while the same edge writes
  // it gives read-before-write for a same-index collision.
  // ---------------------------------------------------------------------------
  logic pred_resp_valid_q;
  logic pred_taken_q;
  idx_t pred_hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_resp_valid_q <= 1'b0;
      pred_taken_q      <= 1'b0;
      pred_hist_q       <= '0;
    end else begin
      pred_resp_valid_q <= bus.pred_valid;
      if (bus.pred_valid) begin
        pred_taken_q <= table_q[pred_idx][1];
        pred_hist_q  <= hist_cur;
      end
    end
  end

  assign bus.pred_resp_valid = pred_resp_valid_q;
  assign bus.pred_taken      = pred_taken_q;
  assign bus.pred_hist       = pred_hist_q;

  // ---------------------------------------------------------------------------
  // Mispredict pulse and statistics
  // ---------------------------------------------------------------------------
  logic             misp_now;
  logic             mispredict_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] br_count_d;
  logic [CNT_W-1:0] mispred_count_q;
  logic [CNT_W-1:0] mispred_count_d;

  assign misp_now = bus.upd_valid && (bus.upd_taken != bus.upd_pred);

  // Clear has priority over counting; the branch coincident with a clear is dropped.
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (bus.stats_clr) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end else if (bus.upd_valid) begin
      if (br_count_q != '1) begin
        br_count_d = br_count_q + CNT_W'(1);
      end
      if (misp_now && (mispred_count_q != '1)) begin
        mispred_count_d = mispred_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_q    <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      mispredict_q    <= misp_now;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign bus.mispredict    = mispredict_q;
  assign bus.br_count      = br_count_q;
  assign bus.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor. A second instance with 2-bit
// statistics counters shares the stimulus so counter saturation is observable.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predictor_if #(.INDEX_BITS(6), .CNT_W(32)) bus ();
  branch_predictor_if #(.INDEX_BITS(6), .CNT_W(2))  bus_s ();

  assign bus_s.pred_valid = bus.pred_valid;
  assign bus_s.pred_pc    = bus.pred_pc;
  assign bus_s.upd_valid  = bus.upd_valid;
  assign bus_s.upd_pc     = bus.upd_pc;
  assign bus_s.upd_hist   = bus.upd_hist;
  assign bus_s.upd_taken  = bus.upd_taken;
  assign bus_s.upd_pred   = bus.upd_pred;
  assign bus_s.stats_clr  = bus.stats_clr;

  branch_predictor #(.INDEX_BITS(6), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_predictor #(.INDEX_BITS(6), .CNT_W(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic [5:0]  uh;
    logic        ut;
    logic        up;
    logic        clr;
    logic        e_rv;
    logic        e_t;
    logic [5:0]  e_h;
    logic        e_m;
    int unsigned e_br;
    int unsigned e_mp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  function automatic void add(input logic pv, input logic [31:0] ppc, input logic uv,
                              input logic [31:0] upc, input logic [5:0] uh, input logic ut,
                              input logic up, input logic clr, input logic e_rv,
                              input logic e_t, input logic [5:0] e_h, input logic e_m,
                              input int unsigned e_br, input int unsigned e_mp);
    vecs.push_back('{pv, ppc, uv, upc, uh, ut, up, clr, e_rv, e_t, e_h, e_m, e_br, e_mp});
  endfunction

  function automatic int unsigned sat3(input int unsigned x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic rv, input logic t,
                            input logic [5:0] h, input logic m, input int unsigned br,
                            input int unsigned mp);
    chk({tag, " pred_resp_valid"}, 32'(bus.pred_resp_valid), 32'(rv));
    chk({tag, " pred_taken"}, 32'(bus.pred_taken), 32'(t));
    chk({tag, " pred_hist"}, 32'(bus.pred_hist), 32'(h));
    chk({tag, " mispredict"}, 32'(bus.mispredict), 32'(m));
    chk({tag, " br_count"}, bus.br_count, br);
    chk({tag, " mispred_count"}, bus.mispred_count, mp);
    chk({tag, " sat br_count"}, 32'(bus_s.br_count), sat3(br));
    chk({tag, " sat mispred_count"}, 32'(bus_s.mispred_count), sat3(mp));
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    bus.pred_valid = v.pv;
    bus.pred_pc    = v.ppc;
    bus.upd_valid  = v.uv;
    bus.upd_pc     = v.upc;
    bus.upd_hist   = v.uh;
    bus.upd_taken  = v.ut;
    bus.upd_pred   = v.up;
    bus.stats_clr  = v.clr;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    check_outs(tag, v.e_rv, v.e_t, v.e_h, v.e_m, v.e_br, v.e_mp);
  endtask

  initial begin
    vec_t idle;
    idle = '{1'b0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 6'h0, 1'b0, 0, 0};

    rst            = 1'b0;
    bus.pred_valid = 1'b0;
    bus.pred_pc    = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_hist   = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_pred   = 1'b0;
    bus.stats_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, 6'h0, 1'b0, 0, 0);
    rst = 1'b1;

`ifndef BP_GSHARE_EN
    //  pv  ppc         uv  upc        uh  ut  up  clr  rv  t   h   m   br  mp
    add(1, 32'h40,  0, 32'h0,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0);  // first lookup
    add(0, 32'h0,   0, 32'h40, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0);  // invalid update ignored
    add(0, 32'h0,   1, 32'h40, 0, 1, 0, 0,  0, 0, 0, 1,  1, 1);  // 01->10
    add(0, 32'h0,   1, 32'h40, 0, 1, 1, 0,  0, 0, 0, 0,  2, 1);  // 10->11
    add(1, 32'h40,  0, 32'h0,  0, 0, 0, 0,  1, 1, 0, 0,  2, 1);
    add(0, 32'h0,   1, 32'h40, 0, 0, 1, 0,  0, 1, 0, 1,  3, 2);  // 11->10
    add(1, 32'h40,  0, 32'h0,  0, 0, 0, 0,  1, 1, 0, 0,  3, 2);
    add(0, 32'h0,   1, 32'h40, 0, 0, 1, 0,  0, 1, 0, 1,  4, 3);  // 10->01
    add(1, 32'h40,  0, 32'h0,  0, 0, 0, 0,  1, 0, 0, 0,  4, 3);
    for (int i = 0; i < 5; i++)                                  // saturate at 11
      add(0, 32'h0, 1, 32'h40, 0, 1, 1, 0,  0, 0, 0, 0,  5 + i, 3);
    add(0, 32'h0,   1, 32'h40, 0, 0, 0, 0,  0, 0, 0, 0, 10, 3);  // 11->10
    add(1, 32'h40,  0, 32'h0,  0, 0, 0, 0,  1, 1, 0, 0, 10, 3);
    add(1, 32'h140, 0, 32'h0,  0, 0, 0, 0,  1, 1, 0, 0, 10, 3);  // alias of index 16
    add(1, 32'h44,  0, 32'h0,  0, 0, 0, 0,  1, 0, 0, 0, 10, 3);  // neighbour untouched
    add(0, 32'h0,   1, 32'h40, 0, 0, 0, 0,  0, 0, 0, 0, 11, 3);  // 10->01
    add(1, 32'h40,  1, 32'h40, 0, 1, 0, 0,  1, 0, 0, 1, 12, 4);  // collision: old value
    add(1, 32'h40,  0, 32'h0,  0, 0, 0, 0,  1, 1, 0, 0, 12, 4);  // write landed
    add(0, 32'h0,   1, 32'h40, 0, 0, 1, 1,  0, 1, 0, 1,  0, 0);  // clear wins, 10->01
    add(1, 32'h40,  0, 32'h0,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0);
    add(0, 32'h0,   1, 32'h80, 0, 1, 1, 0,  0, 0, 0, 0,  1, 0);  // idx32 01->10
    add(0, 32'h0,   0, 32'h0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0);  // clear alone
    add(0, 32'h0,   1, 32'h80, 0, 0, 1, 0,  0, 0, 0, 1,  1, 1);  // idx32 10->01
    add(0, 32'h0,   0, 32'h0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 1);  // pulse is one cycle
    add(0, 32'h0,   1, 32'h80, 0, 1, 0, 1,  0, 0, 0, 1,  0, 0);  // idx32 01->10
    add(0, 32'h0,   0, 32'h0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 32'h0,   1, 32'h80, 0, 1, 0, 0,  0, 0, 0, 1,  1, 1);  // idx32 10->11
    add(1, 32'h80,  1, 32'h80, 0, 0, 1, 0,  1, 1, 0, 1,  2, 2);  // idx32 11->10
`else
    add(0, 32'h0,   1, 32'h40, 0,  1, 1, 0,  0, 0, 0,  0, 1, 0);  // idx16, ghr=1
    for (int i = 0; i < 3; i++)                                   // idx31 -> 11, ghr=15
      add(0, 32'h0, 1, 32'h40, 15, 1, 1, 0,  0, 0, 0,  0, 2 + i, 0);
    add(1, 32'h40,  0, 32'h0,  0,  0, 0, 0,  1, 1, 15, 0, 4, 0);  // 16^15 = 31
    add(1, 32'h44,  0, 32'h0,  0,  0, 0, 0,  1, 0, 15, 0, 4, 0);  // 17^15 = 30
    add(1, 32'h40,  1, 32'h0,  0,  1, 0, 0,  1, 1, 15, 1, 5, 1);  // pre-shift ghr
    add(1, 32'h40,  0, 32'h0,  0,  0, 0, 0,  1, 0, 31, 0, 5, 1);  // 16^31 = 15
    add(0, 32'h0,   1, 32'h0,  0,  0, 0, 0,  0, 0, 31, 0, 6, 1);  // ghr=62
    add(1, 32'h40,  0, 32'h0,  0,  0, 0, 0,  1, 0, 62, 0, 6, 1);  // 16^62 = 46
`endif

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

`ifndef BP_GSHARE_EN
    // Asynchronous reset in the middle of a cycle with a lookup and update in flight.
    begin
      vec_t busy;
      busy = idle;
      busy.pv  = 1'b1;
      busy.ppc = 32'h80;
      busy.uv  = 1'b1;
      busy.upc = 32'h80;
      busy.ut  = 1'b1;
      busy.up  = 1'b0;
      drive(busy);
      #2 rst = 1'b0;
      #1 check_outs("async_rst", 1'b0, 1'b0, 6'h0, 1'b0, 0, 0);
      @(posedge clk);
      #1 check_outs("rst_hold", 1'b0, 1'b0, 6'h0, 1'b0, 0, 0);
      drive(idle);
      rst = 1'b1;
    end
    begin
      vec_t v;
      v = idle;
      v.pv = 1'b1;
      v.ppc = 32'h80;
      v.e_rv = 1'b1;
      apply(v, "post_rst idx32");   // table back to weak not-taken
      v.ppc = 32'h40;
      apply(v, "post_rst idx16");
      apply(idle, "post_rst idle");
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
